// File: rtl/e_md_sequencer.sv
// E-stage multiply/divide sequencer and owner of the HI/LO registers.
// Optional macro MD_DIVZERO_HOLD_EN: a divide by zero keeps the prior HI/LO instead of committing.
module e_md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdOp,
    input  logic        mdValid,
    input  logic        cancel,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    input  logic        dUsesMd,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    md_op_e           op;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic [63:0]      rs_sx, rt_sx, prod_s, prod_u;
    logic             rs_neg, rt_neg, rt_zero;
    logic [31:0]      rs_mag, rt_mag, quot_mag, rem_mag;
    logic [31:0]      quot_s, rem_s, quot_u, rem_u;
    logic [31:0]      res_hi, res_lo;
    logic             res_wr;
    logic [CNT_W-1:0] res_cnt;
    logic             is_md_op;
    logic             issue, mt_ok;

    assign op = md_op_e'(mdOp);

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
    always_comb begin
        rs_sx    = {{32{rsData[31]}}, rsData};
        rt_sx    = {{32{rtData[31]}}, rtData};
        prod_s   = rs_sx * rt_sx;
        prod_u   = {32'd0, rsData} * {32'd0, rtData};
        rt_zero  = (rtData == '0);
        rs_neg   = rsData[31];
        rt_neg   = rtData[31];
        rs_mag   = rs_neg ? (32'd0 - rsData) : rsData;
        rt_mag   = rt_neg ? (32'd0 - rtData) : rtData;
        quot_mag = rt_zero ? '0 : (rs_mag / rt_mag);
        rem_mag  = rt_zero ? '0 : (rs_mag % rt_mag);
        quot_s   = (rs_neg ^ rt_neg) ? (32'd0 - quot_mag) : quot_mag;
        rem_s    = rs_neg ? (32'd0 - rem_mag) : rem_mag;
        quot_u   = rt_zero ? '0 : (rsData / rtData);
        rem_u    = rt_zero ? '0 : (rsData % rtData);
    end

    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        res_wr   = 1'b0;
        res_cnt  = '0;
        is_md_op = 1'b0;
        case (op)
            OP_MULT: begin
                is_md_op = 1'b1;
                res_wr   = 1'b1;
                res_hi   = prod_s[63:32];
                res_lo   = prod_s[31:0];
                res_cnt  = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
                is_md_op = 1'b1;
                res_wr   = 1'b1;
                res_hi   = prod_u[63:32];
                res_lo   = prod_u[31:0];
                res_cnt  = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                is_md_op = 1'b1;
                res_cnt  = CNT_W'(DIV_CYCLES);
                if (rt_zero) begin
`ifdef MD_DIVZERO_HOLD_EN
                    res_wr = 1'b0;
`else
                    res_wr = 1'b1;
                    res_hi = rsData;
                    res_lo = '1;
`endif
                end else begin
                    res_wr = 1'b1;
                    res_hi = (op == OP_DIV) ? rem_s  : rem_u;
                    res_lo = (op == OP_DIV) ? quot_s : quot_u;
                end
            end
            default: ;
        endcase
    end

    // Nothing is accepted while reset is held, so start/stall stay quiet during reset.
    assign mt_ok = reset && mdValid && !cancel && (state_q == IDLE);
    assign issue = mt_ok && is_md_op;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    cnt_d     = res_cnt;
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = res_wr;
                end else if (mt_ok && (op == OP_MTHI)) begin
                    hi_d = rsData;
                end else if (mt_ok && (op == OP_MTLO)) begin
                    lo_d = rsData;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign start = issue;
    assign busy  = busy_q;
    assign stall = dUsesMd && (issue || busy_q);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_e_md_sequencer.sv
// Directed bench for e_md_sequencer; expectations follow MD_DIVZERO_HOLD_EN when it is defined.
module tb_e_md_sequencer;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mdOp;
    logic        mdValid;
    logic        cancel;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        dUsesMd;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    e_md_sequencer #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mdOp   (mdOp),
        .mdValid(mdValid),
        .cancel (cancel),
        .rsData (rsData),
        .rtData (rtData),
        .dUsesMd(dUsesMd),
        .start  (start),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    // Issue one op, then watch start/busy/stall through every busy cycle and the first idle cycle.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned n, input logic uses);
        mdOp = op; mdValid = 1'b1; cancel = 1'b0; rsData = a; rtData = b; dUsesMd = uses;
        #1;
        total++; if (start !== 1'b1) $display("FAIL %s_start got %b exp 1", name, start); else passed++;
        total++; if (stall !== uses) $display("FAIL %s_stall_issue got %b exp %b", name, stall, uses); else passed++;
        for (int i = 0; i < int'(n); i++) begin
            @(posedge clk); #1;
            if (i == 0) begin mdValid = 1'b0; mdOp = 3'b000; end
            #1;
            total++; if (busy !== 1'b1) $display("FAIL %s_busy c%0d got %b exp 1", name, i, busy); else passed++;
            total++; if (start !== 1'b0) $display("FAIL %s_start_run c%0d got %b exp 0", name, i, start); else passed++;
            total++; if (stall !== uses) $display("FAIL %s_stall_run c%0d got %b exp %b", name, i, stall, uses); else passed++;
        end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL %s_busy_done got %b exp 0", name, busy); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL %s_stall_done got %b exp 0", name, stall); else passed++;
        dUsesMd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mdOp = 3'b001; mdValid = 1'b1; cancel = 1'b0;
        rsData = 32'hFFFF_FFFF; rtData = 32'h0000_0002; dUsesMd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h exp 00000000", hi); else passed++;
        total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h exp 00000000", lo); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        total++; if (start !== 1'b0) $display("FAIL reset_start got %b exp 0", start); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        mdValid = 1'b0; mdOp = 3'b000; dUsesMd = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        run_op("mult", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, MC, 1'b0);
        total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp FFFFFFFF", hi); else passed++;
        total++; if (lo !== 32'hFFFF_FFFE) $display("FAIL mult_lo got %h exp FFFFFFFE", lo); else passed++;
        run_op("multu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, MC, 1'b0);
        total++; if (hi !== 32'h0000_0001) $display("FAIL multu_hi got %h exp 00000001", hi); else passed++;
        total++; if (lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo got %h exp FFFFFFFE", lo); else passed++;
    endtask

    task automatic test_div();
        run_op("div_neg", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, DC, 1'b0);
        total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got %h exp FFFFFFFD", lo); else passed++;
        total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got %h exp FFFFFFFF", hi); else passed++;
        run_op("divu", 3'b100, 32'h0000_0007, 32'h0000_0002, DC, 1'b0);
        total++; if (lo !== 32'h0000_0003) $display("FAIL divu_lo got %h exp 00000003", lo); else passed++;
        total++; if (hi !== 32'h0000_0001) $display("FAIL divu_hi got %h exp 00000001", hi); else passed++;
        run_op("div_negdiv", 3'b011, 32'h0000_0007, 32'hFFFF_FFFE, DC, 1'b0);
        total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_negdiv_lo got %h exp FFFFFFFD", lo); else passed++;
        total++; if (hi !== 32'h0000_0001) $display("FAIL div_negdiv_hi got %h exp 00000001", hi); else passed++;
        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, DC, 1'b0);
        total++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h exp 80000000", lo); else passed++;
        total++; if (hi !== 32'h0000_0000) $display("FAIL div_ovf_hi got %h exp 00000000", hi); else passed++;
    endtask

    // Entered with hi=00000000 lo=80000000 left by the overflow divide.
    task automatic test_cancel();
        mdOp = 3'b001; mdValid = 1'b1; cancel = 1'b1; rsData = 32'd3; rtData = 32'd4;
        #1;
        total++; if (start !== 1'b0) $display("FAIL cancel_start got %b exp 0", start); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL cancel_busy got %b exp 0", busy); else passed++;
        total++; if (hi !== 32'h0) $display("FAIL cancel_hi got %h exp 00000000", hi); else passed++;
        total++; if (lo !== 32'h8000_0000) $display("FAIL cancel_lo got %h exp 80000000", lo); else passed++;
        mdOp = 3'b101; rsData = 32'h0000_1234;
        @(posedge clk); #1;
        total++; if (hi !== 32'h0) $display("FAIL mthi_cancel got %h exp 00000000", hi); else passed++;
        cancel = 1'b0;
        #1;
        total++; if (start !== 1'b0) $display("FAIL mthi_start got %b exp 0", start); else passed++;
        @(posedge clk); #1;
        total++; if (hi !== 32'h0000_1234) $display("FAIL mthi_hi got %h exp 00001234", hi); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mthi_busy got %b exp 0", busy); else passed++;
        mdOp = 3'b110; rsData = 32'h0000_5678;
        @(posedge clk); #1;
        total++; if (lo !== 32'h0000_5678) $display("FAIL mtlo_lo got %h exp 00005678", lo); else passed++;
        total++; if (hi !== 32'h0000_1234) $display("FAIL mtlo_hi got %h exp 00001234", hi); else passed++;
        mdOp = 3'b111; rsData = 32'hDEAD_BEEF;
        #1;
        total++; if (start !== 1'b0) $display("FAIL op7_start got %b exp 0", start); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL op7_busy got %b exp 0", busy); else passed++;
        total++; if (hi !== 32'h0000_1234) $display("FAIL op7_hi got %h exp 00001234", hi); else passed++;
        mdOp = 3'b101; mdValid = 1'b0;
        @(posedge clk); #1;
        total++; if (hi !== 32'h0000_1234) $display("FAIL mthi_bubble got %h exp 00001234", hi); else passed++;
        mdOp = 3'b000;
    endtask

    task automatic test_stall();
        run_op("stall_mult", 3'b001, 32'd3, 32'd5, MC, 1'b1);
        total++; if (lo !== 32'd15) $display("FAIL stall_mult_lo got %h exp 0000000F", lo); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL stall_mult_hi got %h exp 00000000", hi); else passed++;
    endtask

    task automatic test_reset_mid_run();
        mdOp = 3'b101; mdValid = 1'b1; cancel = 1'b0; rsData = 32'h0000_AAAA;
        @(posedge clk); #1;
        mdOp = 3'b011; rsData = 32'd100; rtData = 32'd7;
        #1;
        total++; if (start !== 1'b1) $display("FAIL midrst_start got %b exp 1", start); else passed++;
        @(posedge clk); #1;
        mdValid = 1'b0; mdOp = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else passed++;
        total++; if (hi !== 32'h0) $display("FAIL midrst_hi got %h exp 00000000", hi); else passed++;
        total++; if (lo !== 32'h0) $display("FAIL midrst_lo got %h exp 00000000", lo); else passed++;
        repeat (DC + 2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_late_busy got %b exp 0", busy); else passed++;
        total++; if (hi !== 32'h0) $display("FAIL midrst_late_hi got %h exp 00000000", hi); else passed++;
        total++; if (lo !== 32'h0) $display("FAIL midrst_late_lo got %h exp 00000000", lo); else passed++;
    endtask

    // Ops presented during RUN are ignored; a mult held on the inputs issues in the first idle cycle.
    task automatic test_back_to_back();
        mdOp = 3'b100; mdValid = 1'b1; cancel = 1'b0; rsData = 32'd100; rtData = 32'd7;
        #1;
        total++; if (start !== 1'b1) $display("FAIL b2b_start got %b exp 1", start); else passed++;
        @(posedge clk); #1;
        for (int i = 1; i <= int'(DC); i++) begin
            if (i <= 4) begin mdOp = 3'b101; rsData = 32'hDEAD_0000; end
            else begin mdOp = 3'b001; rsData = 32'd6; rtData = 32'd7; end
            #1;
            total++; if (busy !== 1'b1) $display("FAIL b2b_busy c%0d got %b exp 1", i, busy); else passed++;
            total++; if (start !== 1'b0) $display("FAIL b2b_start_run c%0d got %b exp 0", i, start); else passed++;
            @(posedge clk); #1;
        end
        #1;
        total++; if (busy !== 1'b0) $display("FAIL b2b_commit_busy got %b exp 0", busy); else passed++;
        total++; if (hi !== 32'd2) $display("FAIL b2b_divu_hi got %h exp 00000002", hi); else passed++;
        total++; if (lo !== 32'd14) $display("FAIL b2b_divu_lo got %h exp 0000000E", lo); else passed++;
        total++; if (start !== 1'b1) $display("FAIL b2b_reissue got %b exp 1", start); else passed++;
        @(posedge clk); #1;
        mdValid = 1'b0; mdOp = 3'b000;
        total++; if (busy !== 1'b1) $display("FAIL b2b_mult_busy got %b exp 1", busy); else passed++;
        repeat (MC - 1) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("FAIL b2b_mult_last got %b exp 1", busy); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL b2b_mult_done got %b exp 0", busy); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL b2b_mult_hi got %h exp 00000000", hi); else passed++;
        total++; if (lo !== 32'd42) $display("FAIL b2b_mult_lo got %h exp 0000002A", lo); else passed++;
    endtask

    task automatic test_divzero();
        logic [31:0] exp_hi, exp_lo;
        mdOp = 3'b101; mdValid = 1'b1; cancel = 1'b0; rsData = 32'h0000_A5A5;
        @(posedge clk); #1;
        mdOp = 3'b110; rsData = 32'h0000_5A5A;
        @(posedge clk); #1;
        mdValid = 1'b0; mdOp = 3'b000;
        run_op("div0", 3'b011, 32'h0000_0010, 32'h0, DC, 1'b0);
`ifdef MD_DIVZERO_HOLD_EN
        exp_hi = 32'h0000_A5A5; exp_lo = 32'h0000_5A5A;
`else
        exp_hi = 32'h0000_0010; exp_lo = 32'hFFFF_FFFF;
`endif
        total++; if (hi !== exp_hi) $display("FAIL div0_hi got %h exp %h", hi, exp_hi); else passed++;
        total++; if (lo !== exp_lo) $display("FAIL div0_lo got %h exp %h", lo, exp_lo); else passed++;
        run_op("divu0", 3'b100, 32'h0000_0020, 32'h0, DC, 1'b0);
`ifdef MD_DIVZERO_HOLD_EN
        exp_hi = 32'h0000_A5A5; exp_lo = 32'h0000_5A5A;
`else
        exp_hi = 32'h0000_0020; exp_lo = 32'hFFFF_FFFF;
`endif
        total++; if (hi !== exp_hi) $display("FAIL divu0_hi got %h exp %h", hi, exp_hi); else passed++;
        total++; if (lo !== exp_lo) $display("FAIL divu0_lo got %h exp %h", lo, exp_lo); else passed++;
    endtask

    initial begin
        reset = 1'b0; mdOp = 3'b000; mdValid = 1'b0; cancel = 1'b0;
        rsData = 32'h0; rtData = 32'h0; dUsesMd = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_cancel();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_divzero();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
